// File: rtl/text_render_if.sv
// Memory-side bus of the text renderer: text RAM read port and font ROM read port.
//   text_adb  : text RAM read address {row[4:0], col[4:0]}
//   text_ceb  : text RAM read enable
//   text_dout : text RAM word, [15:8] attribute, [7:0] character code (1-cycle latency)
//   font_addr : font ROM address {char[7:0], glyph_row[2:0]}
//   font_data : font ROM glyph row, bit 7 leftmost (1-cycle latency)
// master = renderer side, slave = memory side.
interface text_render_if;
  logic [9:0]  text_adb;
  logic        text_ceb;
  logic [15:0] text_dout;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output text_adb,
    output text_ceb,
    output font_addr,
    input  text_dout,
    input  font_data
  );

  modport slave (
    input  text_adb,
    input  text_ceb,
    input  font_addr,
    output text_dout,
    output font_data
  );
endinterface

// File: rtl/text_render.sv
// Character-cell text renderer: 32x30 grid of 8x8 glyphs scaled x2 (16x16 px cells).
// Three-stage pipeline: T0 issues the text RAM read, T1 issues the font ROM read,
// T2 selects the glyph bit and registers the colour. Timing signals are delayed
// alongside so de_out/hs_out/vs_out stay aligned with pix_color (3 clk latency).
//
// Ports:
//   clk, rst            : pixel clock, synchronous active-high reset
//   de_in, hs_in, vs_in : timing from the VGA generator
//   x_in, y_in          : current pixel column / line
//   mem                 : text RAM / font ROM bus (text_render_if.master)
//   de_out, hs_out,     : delayed timing, aligned with pix_color
//   vs_out
//   pix_color           : 4-bit colour index of the current pixel
//
// Optional feature: define TEXT_RENDER_BLINK_EN to enable attribute bit 7 blinking,
// driven by a 6-bit frame counter advanced on each vs_in falling edge.
module text_render #(
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [9:0]    x_in,
  input  logic [9:0]    y_in,
  text_render_if.master mem,
  output logic          de_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic [3:0]    pix_color
);

  // Stage 1 (RAM data valid)
  logic       de_d1, hs_d1, vs_d1, act_d1;
  logic [2:0] x_d1, y_d1;
  // Stage 2 (font data valid)
  logic       de_d2, hs_d2, vs_d2, act_d2;
  logic [2:0] x_d2;
  logic [7:0] attr_d2;

  logic       act_in;
  logic       pix_bit;
  logic       hide;
  logic [3:0] fg, bg, color_d;

  // x_in[9] set means column 512+, which also covers the address wrap case.
  assign act_in = ~x_in[9] & (y_in < 10'd480);

  assign mem.text_adb  = {y_in[8:4], x_in[8:4]};
  assign mem.text_ceb  = ~rst;
  assign mem.font_addr = {mem.text_dout[7:0], y_d1};

  always_ff @(posedge clk) begin
    if (rst) begin
      de_d1     <= 1'b0;
      hs_d1     <= SYNC_IDLE;
      vs_d1     <= SYNC_IDLE;
      act_d1    <= 1'b0;
      x_d1      <= 3'd0;
      y_d1      <= 3'd0;
      de_d2     <= 1'b0;
      hs_d2     <= SYNC_IDLE;
      vs_d2     <= SYNC_IDLE;
      act_d2    <= 1'b0;
      x_d2      <= 3'd0;
      attr_d2   <= 8'd0;
      de_out    <= 1'b0;
      hs_out    <= SYNC_IDLE;
      vs_out    <= SYNC_IDLE;
      pix_color <= 4'd0;
    end else begin
      de_d1     <= de_in;
      hs_d1     <= hs_in;
      vs_d1     <= vs_in;
      act_d1    <= act_in;
      x_d1      <= x_in[3:1];
      y_d1      <= y_in[3:1];
      de_d2     <= de_d1;
      hs_d2     <= hs_d1;
      vs_d2     <= vs_d1;
      act_d2    <= act_d1;
      x_d2      <= x_d1;
      attr_d2   <= mem.text_dout[15:8];
      de_out    <= de_d2;
      hs_out    <= hs_d2;
      vs_out    <= vs_d2;
      pix_color <= color_d;
    end
  end

`ifdef TEXT_RENDER_BLINK_EN
  logic [5:0] frame_q;
  logic       vs_prev_q;

  always_ff @(posedge clk) begin
    // vs history is tracked through reset so release never fakes a falling edge.
    vs_prev_q <= vs_in;
    if (rst) begin
      frame_q <= 6'd0;
    end else if (vs_prev_q && !vs_in) begin
      frame_q <= frame_q + 6'd1;
    end
  end

  assign hide = attr_d2[7] & frame_q[5];

  // Bit 0 of x only selects within a 2x-scaled pixel.
  logic unused_bits;
  assign unused_bits = x_in[0];
`else
  assign hide = 1'b0;

  // Bit 0 of x only selects within a 2x-scaled pixel; attr[7] has no meaning here.
  logic unused_bits;
  assign unused_bits = ^{x_in[0], attr_d2[7]};
`endif

  always_comb begin
    pix_bit = mem.font_data[3'd7 - x_d2];
    bg      = {1'b0, attr_d2[6:4]};
    fg      = hide ? bg : attr_d2[3:0];
    color_d = 4'd0;
    if (de_d2 && act_d2) begin
      color_d = pix_bit ? fg : bg;
    end
  end

endmodule

// File: tb/tb_text_render.sv
module tb_text_render;

  logic       clk = 1'b0;
  logic       rst;
  logic       de_in, hs_in, vs_in;
  logic [9:0] x_in, y_in;
  logic       de_out, hs_out, vs_out;
  logic [3:0] pix_color;

  always #5 clk = ~clk;

  text_render_if mem_if ();

  text_render #(
    .SYNC_IDLE(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .de_in    (de_in),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .x_in     (x_in),
    .y_in     (y_in),
    .mem      (mem_if),
    .de_out   (de_out),
    .hs_out   (hs_out),
    .vs_out   (vs_out),
    .pix_color(pix_color)
  );

  // Memory models: registered reads, one cycle of latency each.
  logic [15:0] ram  [1024];
  logic [7:0]  font [2048];

  always @(posedge clk) begin
    if (mem_if.text_ceb) mem_if.text_dout <= ram[mem_if.text_adb];
    mem_if.font_data <= font[mem_if.font_addr];
  end

  typedef struct packed {
    logic [3:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   frames;
  bit   prev_vs;

  // Reference: what the screen should show at (x,y), straight from the cell rules.
  function automatic logic [3:0] model_pix(input int x, input int y, input bit de);
    int col, row, word, ch, attr, g, b, fg, bg;
    if (!de || x >= 512 || y >= 480) return 4'd0;
    col  = (x / 16) % 32;
    row  = (y / 16) % 32;
    word = int'(ram[row * 32 + col]);
    ch   = word % 256;
    attr = word / 256;
    g    = int'(font[ch * 8 + (y % 16) / 2]);
    b    = (g >> (7 - (x % 16) / 2)) & 1;
    fg   = attr % 16;
    bg   = (attr / 16) % 8;
`ifdef TEXT_RENDER_BLINK_EN
    if (attr >= 128 && (frames % 64) >= 32) fg = bg;
`endif
    return 4'((b != 0) ? fg : bg);
  endfunction

  // Drive one pixel cycle; e is what the outputs must show in this same cycle.
  task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs,
                      output exp_t e);
    exp_t n;
    @(posedge clk);
    #1;
    x_in  = 10'(x);
    y_in  = 10'(y);
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    n.pix = model_pix(x, y, de);
    n.de  = de;
    n.hs  = hs;
    n.vs  = vs;
    q.push_back(n);
    if (prev_vs && !vs) frames++;
    prev_vs = vs;
    @(negedge clk);
    e = q.pop_front();
  endtask

  task automatic drive_random();
    x_in  = 10'($urandom_range(0, 1023));
    y_in  = 10'($urandom_range(0, 1023));
    de_in = 1'($urandom_range(0, 1));
    hs_in = 1'($urandom_range(0, 1));
    vs_in = 1'($urandom_range(0, 1));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    x_in = '0; y_in = '0; de_in = 0; hs_in = 0; vs_in = 0;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    q.push_back(exp_t'{pix: 4'd0, de: 1'b0, hs: 1'b1, vs: 1'b1});
    q.push_back(exp_t'{pix: 4'd0, de: 1'b0, hs: 1'b1, vs: 1'b1});
    q.push_back(exp_t'{pix: 4'd0, de: 1'b0, hs: 1'b0, vs: 1'b0});
    frames  = 0;
    prev_vs = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    drive_random();
    repeat (3) begin
      @(posedge clk);
      #1;
      drive_random();
    end
    release_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1;
    drive_random();
    @(negedge clk);
    checks++;
    if (mem_if.text_ceb !== 1'b0) begin
      errors++;
      $display("FAIL reset_ceb_first: got %b want 0", mem_if.text_ceb);
    end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      drive_random();
      @(negedge clk);
      checks++;
      if ({pix_color, de_out, hs_out, vs_out, mem_if.text_ceb} !== 8'b0000_0_1_1_0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got pix=%h de=%b hs=%b vs=%b ceb=%b want 0 0 1 1 0",
                 i, pix_color, de_out, hs_out, vs_out, mem_if.text_ceb);
      end
    end
    release_reset();
    @(negedge clk);
    checks++;
    if (mem_if.text_ceb !== 1'b1) begin
      errors++;
      $display("FAIL ceb_after_reset: got %b want 1", mem_if.text_ceb);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    ram[0] = 16'h077C;
    font[11'h3E0] = 8'h80;
    step(0, 0, 1, 1, 0, e);
    checks++;
    if (mem_if.text_adb !== 10'd0) begin
      errors++;
      $display("FAIL latency_adb: got %h want 000", mem_if.text_adb);
    end
    step(0, 0, 0, 1, 0, e);
    checks++;
    if (mem_if.font_addr !== 11'h3E0) begin
      errors++;
      $display("FAIL latency_font_addr: got %h want 3e0", mem_if.font_addr);
    end
    step(0, 0, 0, 1, 0, e);
    checks++;
    if (de_out !== 1'b0 || de_out !== e.de) begin
      errors++;
      $display("FAIL latency_early_de: got %b want 0", de_out);
    end
    step(0, 0, 0, 1, 0, e);
    checks++;
    if (pix_color !== 4'h7 || pix_color !== e.pix || de_out !== 1'b1) begin
      errors++;
      $display("FAIL latency_pix: got pix=%h de=%b want pix=7 de=1", pix_color, de_out);
    end
  endtask

  task automatic test_scaling();
    exp_t e;
    logic [3:0] want;
    ram[0] = 16'h1E41;
    font[11'd520] = 8'h40;
    for (int i = 0; i < 7; i++) begin
      step((i < 4) ? i : 0, 0, i < 4, 1, 0, e);
      if (i >= 3) begin
        want = (i - 3 < 2) ? 4'h1 : 4'hE;
        checks++;
        if (pix_color !== want || pix_color !== e.pix) begin
          errors++;
          $display("FAIL scaling_x%0d: got %h want %h", i - 3, pix_color, want);
        end
      end
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    int xs[7] = '{511, 512, 0, 5, 0, 0, 0};
    int ys[7] = '{479, 0, 480, 5, 0, 0, 0};
    bit ds[7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [3:0] want[4] = '{4'hA, 4'h0, 4'h0, 4'h0};
    ram[0]   = 16'h3541;
    ram[960] = 16'h3541;
    ram[959] = 16'h2A41;
    font[11'd527] = 8'h01;
    for (int i = 0; i < 7; i++) begin
      step(xs[i], ys[i], ds[i], 1, 0, e);
      if (i == 0) begin
        checks++;
        if (mem_if.text_adb !== 10'h3BF) begin
          errors++;
          $display("FAIL boundary_adb: got %h want 3bf", mem_if.text_adb);
        end
      end
      if (i >= 3) begin
        checks++;
        if (pix_color !== want[i - 3] || pix_color !== e.pix) begin
          errors++;
          $display("FAIL boundary_pix[%0d]: got %h want %h", i - 3, pix_color, want[i - 3]);
        end
      end
    end
  endtask

  task automatic test_sync();
    exp_t e;
    int   lows  = 0;
    int   first = -1;
    bit   hs;
    for (int i = 0; i < 119; i++) begin
      hs = !(i >= 10 && i < 106);
      step(0, 0, 0, hs, 0, e);
      checks++;
      if (hs_out !== e.hs) begin
        errors++;
        $display("FAIL sync_hs[%0d]: got %b want %b", i, hs_out, e.hs);
      end
      if (hs_out === 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (lows != 96 || first != 13) begin
      errors++;
      $display("FAIL sync_pulse: got width=%0d start=%0d want 96 13", lows, first);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   x, y;
    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    for (int i = 0; i < 500; i++) begin
      x = $urandom_range(0, 600);
      y = $urandom_range(0, 560);
      step(x, y, ($urandom % 4) != 0, 1'($urandom_range(0, 1)), 0, e);
      checks++;
      if (mem_if.text_adb !== 10'(((y / 16) % 32) * 32 + (x / 16) % 32)) begin
        errors++;
        $display("FAIL b2b_adb[%0d]: got %h for x=%0d y=%0d", i, mem_if.text_adb, x, y);
      end
      checks++;
      if ({pix_color, de_out, hs_out, vs_out} !== e) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got pix=%h de=%b hs=%b vs=%b want pix=%h de=%b hs=%b vs=%b",
                 i, pix_color, de_out, hs_out, vs_out, e.pix, e.de, e.hs, e.vs);
      end
    end
  endtask

  task automatic test_midline_reset();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      step($urandom_range(0, 500), $urandom_range(0, 470), 1, 1, 0, e);
      checks++;
      if (pix_color !== e.pix) begin
        errors++;
        $display("FAIL midline_pre[%0d]: got %h want %h", i, pix_color, e.pix);
      end
    end
    @(posedge clk);
    #1;
    rst = 1;
    x_in = 10'd40;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({pix_color, de_out, hs_out, vs_out} !== 7'b0000_0_1_1) begin
      errors++;
      $display("FAIL midline_reset: got pix=%h de=%b hs=%b vs=%b want 0 0 1 1",
               pix_color, de_out, hs_out, vs_out);
    end
    release_reset();
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(0, 500), $urandom_range(0, 470), 1, 1, 0, e);
      checks++;
      if ({pix_color, de_out} !== {e.pix, e.de} || (i < 3 && (pix_color !== 0 || de_out !== 0)))
      begin
        errors++;
        $display("FAIL midline_after[%0d]: got pix=%h de=%b want pix=%h de=%b",
                 i, pix_color, de_out, e.pix, e.de);
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    logic [3:0] want;
    do_reset();
    ram[0] = 16'h8742;
    font[11'd528] = 8'hFF;
    for (int f = 0; f < 64; f++) begin
      step(0, 0, 1, 1, 0, e);
      step(0, 0, 0, 1, 0, e);
      step(0, 0, 0, 1, 0, e);
      step(0, 0, 0, 1, 0, e);
`ifdef TEXT_RENDER_BLINK_EN
      want = (f >= 32) ? 4'h0 : 4'h7;
`else
      want = 4'h7;
`endif
      checks++;
      if (pix_color !== want || pix_color !== e.pix) begin
        errors++;
        $display("FAIL blink_frame%0d: got %h want %h", f, pix_color, want);
      end
      step(0, 0, 0, 1, 1, e);
      step(0, 0, 0, 1, 0, e);
    end
  endtask

  initial begin
    rst = 1; x_in = '0; y_in = '0; de_in = 0; hs_in = 0; vs_in = 0;
    frames = 0; prev_vs = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    test_reset();
    test_latency();
    test_scaling();
    test_boundary();
    test_sync();
    test_back_to_back();
    test_midline_reset();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_render.md
TEXT_RENDER -- requirements
Module: text_render

Interface
REQ-001 Parameter: SYNC_IDLE, 1'b1, idle level of hs_out/vs_out during and after reset.
REQ-002 clk  input  1  pixel clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 de_in, hs_in, vs_in  input  1 each  display-enable and syncs from the VGA timing generator.
REQ-005 x_in, y_in  input  10 each  current pixel column/line, valid with de_in.
REQ-006 text_adb  output  10  text RAM read address, {row[4:0], col[4:0]}.
REQ-007 text_ceb  output  1  text RAM read enable.
REQ-008 text_dout  input  16  text RAM word: [15:8] attribute, [7:0] character code.
REQ-009 font_addr  output  11  font ROM address, {char[7:0], glyph_row[2:0]}.
REQ-010 font_data  input  8  font ROM glyph row; bit 7 is the leftmost pixel.
REQ-011 de_out, hs_out, vs_out  output  1 each  input timing delayed to align with pix_color.
REQ-012 pix_color  output  4  colour index of the current pixel.

Function
REQ-013 Cell: 8x8 glyph scaled x2, so 16x16 px; grid 32 cols x 30 rows; col = x_in[8:4], row = y_in[8:4].
REQ-014 Active text area: x_in < 512 and y_in < 480; outside it, or with de_in=0, pix_color SHALL be 0.
REQ-015 T0: text_adb = {y_in[8:4], x_in[8:4]}, combinational; text_ceb = 1 except in reset.
REQ-016 T1 (text RAM, 1-cycle latency): font_addr = {text_dout[7:0], y_d1[3:1]}, combinational from text_dout and 1-cycle-delayed y.
REQ-017 T2 (font ROM, 1-cycle latency): pixel bit = font_data[7 - x_d2[3:1]].
REQ-018 Attribute: fg = attr[3:0]; bg = {1'b0, attr[6:4]}; pixel bit 1 gives fg, 0 gives bg.
REQ-019 pix_color is registered at the end of T2; input-to-output latency is exactly 3 clk.
REQ-020 de, hs, vs, x, y and the active-area flag SHALL pass through a 3-stage delay line; de_out/hs_out/vs_out stay cycle-aligned with pix_color.
REQ-021 Address wrap: x_in in 512..1023 gives col = x_in[8:4] with x_in[9] set, which is outside the active area, so the pixel is blanked and nothing is fetched out of range.
REQ-022 A character code change at the RAM (writer on port A) takes effect at the next read of that cell; no frame buffering.

Reset
REQ-023 While rst=1: pix_color=0, de_out=0, hs_out=vs_out=SYNC_IDLE, text_ceb=0, and all delay stages are cleared to those same values.
REQ-024 After rst falls, the first valid pix_color appears 3 clk after the first de_in=1 sample.
REQ-025 Reset asserted mid-line forces the outputs to the REQ-023 values on the next edge; no partial-pipeline data leaks out after release.

Configuration
REQ-026 Macro TEXT_RENDER_BLINK_EN.
REQ-027 Defined: a 6-bit frame counter increments on each vs_in falling edge (reset 0); when attr[7]=1 and counter[5]=1, fg is replaced by bg, so the glyph is hidden for 32 frames of every 64.
REQ-028 Undefined: attr[7] is ignored, there is no counter, and the colour follows REQ-018 only.

Verification
REQ-029 Reset: hold rst 4 clk with random inputs -> pix_color=0, de_out=0, hs_out=vs_out=1, text_ceb=0.
REQ-030 Latency: x=0, y=0, de_in=1, RAM word 0x077C, font_data=0x80 -> text_adb=0, font_addr={0x7C,3'd0}, pix_color=7 exactly 3 clk later, de_out aligned.
REQ-031 Scaling: x=2..3, font_data=0x40, attr 0x1E -> pix_color=0xE on both pixels; x=0..1 gives 1 (bg).
REQ-032 Boundaries: x=511, y=479 -> text_adb=0x3BF; x=512 or y=480 or de_in=0 -> pix_color=0.
REQ-033 Sync alignment: hs_in pulse of 96 clk -> hs_out identical pulse delayed exactly 3 clk.
REQ-034 Blink (macro on): attr 0x87, font_data=0xFF -> pix_color=7 for frames 0-31 and 0 for frames 32-63; macro off -> 7 for all frames.
